// File: rtl/ram_stream_pkg.sv
// rtl/ram_stream_pkg.sv - shared state encoding and default widths for ram_stream_reader
package ram_stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// rtl/stream_skid_buffer.sv - 2-entry fall-through buffer between RAM read data and the output stream
module stream_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            occupancy
);

    logic [DATA_WIDTH-1:0] mem_data [2];
    logic [1:0]            mem_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  empty;
    logic                  bypass;
    logic                  pop;
    logic                  push_store;
    logic                  pop_store;

    // An arriving word goes straight to the output when nothing is queued ahead of it.
    assign empty      = (count == 2'd0);
    assign bypass     = empty && in_valid;
    assign out_valid  = in_valid || !empty;
    assign out_data   = bypass ? in_data : mem_data[rd_ptr];
    assign out_last   = out_valid && (bypass ? in_last : mem_last[rd_ptr]);
    assign pop        = out_valid && out_ready;
    assign push_store = in_valid && !(empty && out_ready);
    assign pop_store  = pop && !empty;
    assign occupancy  = count;

    // Storage, pointers and occupancy; flush drops every queued word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_store) begin
                mem_data[wr_ptr] <= in_data;
                mem_last[wr_ptr] <= in_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_store) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_store} - {1'b0, pop_store};
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - streams LENGTH words from a synchronous RAM per start; abort input under RAM_STREAM_READER_ABORT_EN
module ram_stream_reader
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int START_ADDR = 0,
    parameter int LENGTH     = 512
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef RAM_STREAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH:0]   LAST_IDX   = (ADDR_WIDTH + 1)'(LENGTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   issued;
    logic                  addr_valid;
    logic                  addr_last;
    logic                  rd_valid;
    logic                  rd_last;
    logic [1:0]            occupancy;
    logic [2:0]            committed;
    logic                  pop;
    logic                  issue;
    logic                  abort_hit;
    logic                  done_hit;

`ifdef RAM_STREAM_READER_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Words owed to the buffer after this cycle's handshake: queued, landing now, or addressed.
    assign pop       = m_valid && m_ready;
    assign committed = {1'b0, occupancy} + {2'b0, addr_valid} + {2'b0, rd_valid} - {2'b0, pop};
    assign issue     = (state == RUN) && !abort_hit && (committed < 3'd2);
    assign done_hit  = (state == DRAIN) && pop && m_last;

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_hit),
        .in_data   (ram_data),
        .in_last   (rd_last),
        .in_valid  (rd_valid),
        .out_data  (m_data),
        .out_last  (m_last),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .occupancy (occupancy)
    );

    // Frame FSM, address generator and the one-cycle RAM latency tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_addr   <= FIRST_ADDR;
            next_addr  <= FIRST_ADDR;
            issued     <= '0;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            done       <= 1'b0;
            addr_valid <= issue;
            addr_last  <= issue && (issued == LAST_IDX);
            rd_valid   <= addr_valid;
            rd_last    <= addr_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        next_addr <= FIRST_ADDR;
                        issued    <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        ram_addr  <= next_addr;
                        next_addr <= next_addr + 1'b1;
                        issued    <= issued + 1'b1;
                        if (issued == LAST_IDX) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (abort_hit) begin
                state      <= IDLE;
                busy       <= 1'b0;
                done       <= 1'b1;
                addr_valid <= 1'b0;
                addr_last  <= 1'b0;
                rd_valid   <= 1'b0;
                rd_last    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed self-checking bench for ram_stream_reader
module tb_ram_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic m_ready;
`ifdef RAM_STREAM_READER_ABORT_EN
    logic abort;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];

    logic       busy_a, done_a, m_valid_a, m_last_a;
    logic [3:0] addr_a;
    logic [7:0] rdata_a, data_a;
    logic       busy_b, done_b, m_valid_b, m_last_b;
    logic [3:0] addr_b;
    logic [7:0] rdata_b, data_b;
    logic       busy_c, done_c, m_valid_c, m_last_c;
    logic [3:0] addr_c;
    logic [7:0] rdata_c, data_c;

    ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_ADDR(0), .LENGTH(4)) dut_a (
        .clk(clk), .rst(rst),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort(abort),
`endif
        .start(start), .busy(busy_a), .done(done_a), .ram_addr(addr_a), .ram_data(rdata_a),
        .m_data(data_a), .m_valid(m_valid_a), .m_ready(m_ready), .m_last(m_last_a)
    );

    ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_ADDR(14), .LENGTH(4)) dut_b (
        .clk(clk), .rst(rst),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort(abort),
`endif
        .start(start), .busy(busy_b), .done(done_b), .ram_addr(addr_b), .ram_data(rdata_b),
        .m_data(data_b), .m_valid(m_valid_b), .m_ready(m_ready), .m_last(m_last_b)
    );

    ram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .START_ADDR(0), .LENGTH(8)) dut_c (
        .clk(clk), .rst(rst),
`ifdef RAM_STREAM_READER_ABORT_EN
        .abort(abort),
`endif
        .start(start), .busy(busy_c), .done(done_c), .ram_addr(addr_c), .ram_data(rdata_c),
        .m_data(data_c), .m_valid(m_valid_c), .m_ready(m_ready), .m_last(m_last_c)
    );

    // synchronous RAM models, one read port per instance
    always @(posedge clk) begin
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
        rdata_c <= mem[addr_c];
    end

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;
`ifdef RAM_STREAM_READER_ABORT_EN
        abort   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        total++; if (busy_a !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        total++; if (done_a !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid_a); end
        total++; if (m_last_a !== 1'b0)  begin bad++; $display("FAIL reset_last: got %b want 0", m_last_a); end
        total++; if (data_a !== 8'h00)   begin bad++; $display("FAIL reset_data: got %h want 00", data_a); end
        total++; if (addr_a !== 4'd0)    begin bad++; $display("FAIL reset_addr_a: got %0d want 0", addr_a); end
        total++; if (addr_b !== 4'd14)   begin bad++; $display("FAIL reset_addr_b: got %0d want 14", addr_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stream();
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy_a !== 1'b1)    begin bad++; $display("FAIL stream_busy: got %b want 1", busy_a); end
        total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL stream_early_valid: got %b want 0", m_valid_a); end
        @(negedge clk);
        total++; if (addr_a !== 4'd0)    begin bad++; $display("FAIL stream_first_addr: got %0d want 0", addr_a); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (m_valid_a !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b want 1", k, m_valid_a); end
            total++; if (data_a !== 8'(8'h10 + k)) begin bad++; $display("FAIL stream_data[%0d]: got %h want %h", k, data_a, 8'(8'h10 + k)); end
            total++; if (m_last_a !== (k == 3)) begin bad++; $display("FAIL stream_last[%0d]: got %b want %b", k, m_last_a, (k == 3)); end
            total++; if (done_a !== 1'b0)    begin bad++; $display("FAIL stream_done_early[%0d]: got %b want 0", k, done_a); end
        end
        @(negedge clk);
        total++; if (done_a !== 1'b1)    begin bad++; $display("FAIL stream_done: got %b want 1", done_a); end
        total++; if (busy_a !== 1'b0)    begin bad++; $display("FAIL stream_busy_end: got %b want 0", busy_a); end
        total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL stream_valid_end: got %b want 0", m_valid_a); end
        @(negedge clk);
        total++; if (done_a !== 1'b0)    begin bad++; $display("FAIL stream_done_pulse: got %b want 0", done_a); end
    endtask

    task automatic test_stall();
        logic [5:0] pat;
        logic       held_v;
        logic [7:0] held_d;
        logic       held_l;
        int         got;
        int         dones;
        pat    = 6'b101001;
        held_v = 1'b0;
        held_d = 8'h00;
        held_l = 1'b0;
        got    = 0;
        dones  = 0;
        do_reset();
        start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (c == 1) start = 1'b0;
            if (held_v) begin
                total++;
                if (m_valid_a !== 1'b1 || data_a !== held_d || m_last_a !== held_l) begin
                    bad++;
                    $display("FAIL stall_hold[%0d]: got v=%b d=%h l=%b want v=1 d=%h l=%b", c, m_valid_a, data_a, m_last_a, held_d, held_l);
                end
            end
            m_ready = pat[c % 6];
            if (m_valid_a && m_ready) begin
                total++; if (data_a !== 8'(8'h10 + got)) begin bad++; $display("FAIL stall_data[%0d]: got %h want %h", got, data_a, 8'(8'h10 + got)); end
                total++; if (m_last_a !== (got == 3)) begin bad++; $display("FAIL stall_last[%0d]: got %b want %b", got, m_last_a, (got == 3)); end
                got++;
            end
            held_v = m_valid_a && !m_ready;
            held_d = data_a;
            held_l = m_last_a;
            if (done_a) dones++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        total++; if (got != 4)   begin bad++; $display("FAIL stall_words: got %0d want 4", got); end
        total++; if (dones != 1) begin bad++; $display("FAIL stall_done: got %0d want 1", dones); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_addr [4];
        int         seen_done;
        exp_addr[0] = 4'd14;
        exp_addr[1] = 4'd15;
        exp_addr[2] = 4'd0;
        exp_addr[3] = 4'd1;
        seen_done   = 0;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (addr_b !== exp_addr[k]) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", k, addr_b, exp_addr[k]); end
            if (k == 1) begin
                total++; if (m_valid_b !== 1'b1 || data_b !== 8'h1E) begin bad++; $display("FAIL wrap_first_word: got v=%b d=%h want v=1 d=1e", m_valid_b, data_b); end
            end
        end
        for (int c = 0; c < 20; c++) begin
            if (done_b) seen_done++;
            @(negedge clk);
        end
        total++; if (seen_done != 1) begin bad++; $display("FAIL wrap_done: got %0d want 1", seen_done); end
    endtask

    task automatic test_back_to_back();
        int got;
        int dones;
        got   = 0;
        dones = 0;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            if (done_a) dones++;
            start = (c == 0) || (c == 4) || (done_a && dones == 1);
            if (c == 8) begin
                total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_busy_restart: got %b want 1", busy_a); end
            end
            if (m_valid_a && m_ready) begin
                total++; if (data_a !== 8'(8'h10 + (got % 4))) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", got, data_a, 8'(8'h10 + (got % 4))); end
                if (got == 4) begin
                    total++; if (c != 10) begin bad++; $display("FAIL b2b_second_latency: got cycle %0d want 10", c); end
                end
                got++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++; if (got != 8)   begin bad++; $display("FAIL b2b_words: got %0d want 8", got); end
        total++; if (dones != 2) begin bad++; $display("FAIL b2b_frames: got %0d want 2", dones); end
    endtask

    task automatic test_reset_mid();
        int spurious;
        spurious = 0;
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy_c !== 1'b0)    begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy_c); end
        total++; if (done_c !== 1'b0)    begin bad++; $display("FAIL rstmid_done: got %b want 0", done_c); end
        total++; if (m_valid_c !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", m_valid_c); end
        total++; if (m_last_c !== 1'b0)  begin bad++; $display("FAIL rstmid_last: got %b want 0", m_last_c); end
        total++; if (data_c !== 8'h00)   begin bad++; $display("FAIL rstmid_data: got %h want 00", data_c); end
        total++; if (addr_c !== 4'd0)    begin bad++; $display("FAIL rstmid_addr: got %0d want 0", addr_c); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_c || m_valid_c) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", spurious); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++; if (addr_c !== 4'd0) begin bad++; $display("FAIL rstmid_replay_addr: got %0d want 0", addr_c); end
        @(negedge clk);
        total++; if (m_valid_c !== 1'b1 || data_c !== 8'h10) begin bad++; $display("FAIL rstmid_replay_word: got v=%b d=%h want v=1 d=10", m_valid_c, data_c); end
    endtask

`ifdef RAM_STREAM_READER_ABORT_EN
    task automatic test_abort();
        int seen_last;
        int late_valid;
        seen_last  = 0;
        late_valid = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            abort = (c == 5);
            if (m_last_a) seen_last++;
            if (c == 6) begin
                total++; if (m_valid_a !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", m_valid_a); end
                total++; if (done_a !== 1'b1)    begin bad++; $display("FAIL abort_done: got %b want 1", done_a); end
                total++; if (busy_a !== 1'b0)    begin bad++; $display("FAIL abort_busy: got %b want 0", busy_a); end
            end
            if (c > 6 && (m_valid_a || done_a)) late_valid++;
            @(negedge clk);
        end
        abort = 1'b0;
        total++; if (seen_last != 0)  begin bad++; $display("FAIL abort_last: got %0d want 0", seen_last); end
        total++; if (late_valid != 0) begin bad++; $display("FAIL abort_quiet: got %0d want 0", late_valid); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b1;
`ifdef RAM_STREAM_READER_ABORT_EN
        abort   = 1'b0;
`endif
        test_reset();
        test_stream();
        test_stall();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef RAM_STREAM_READER_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
